// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO (mult/multu/div/divu/mthi/mtlo).
// Each result is computed from the operands captured at launch and written to HI/LO on the final busy edge.
`default_nettype none

module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  mdu_op_i,
  input  logic        flush_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic [31:0] hi_d, lo_d;

  logic        launch;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd, dvs, q_mag, r_mag;

  assign launch = start_i && (mdu_op_i >= OP_MULT) && (mdu_op_i <= OP_DIVU);

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  assign dvd   = (op_q == OP_DIV && a_q[31]) ? -a_q : a_q;
  assign dvs   = (op_q == OP_DIV && b_q[31]) ? -b_q : b_q;
  assign q_mag = dvd / dvs;
  assign r_mag = dvd % dvs;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (op_q)
      OP_MULT:  {hi_d, lo_d} = prod_s;
      OP_MULTU: {hi_d, lo_d} = prod_u;
      OP_DIV: begin
        if (b_q != 32'd0) begin
          lo_d = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
          hi_d = a_q[31] ? -r_mag : r_mag;
        end
      end
      OP_DIVU: begin
        if (b_q != 32'd0) begin
          lo_d = q_mag;
          hi_d = r_mag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!flush_i) begin
            if (launch) begin
              state_q <= S_RUN;
              op_q    <= mdu_op_i;
              a_q     <= a_i;
              b_q     <= b_i;
              cnt_q   <= (mdu_op_i <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end else if (mdu_op_i == OP_MTHI) begin
              hi_q <= a_i;
            end else if (mdu_op_i == OP_MTLO) begin
              lo_q <= a_i;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_IDLE;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// tb_mdu: directed plus randomized checks of mdu against an arithmetic reference model.
`default_nettype none

module tb_mdu;
  logic        clk, rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mdu_op_i(op), .flush_i(flush),
    .a_i(a), .b_i(b), .busy_o(busy), .hi_o(hi), .lo_o(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = $signed(ma);
    sb = $signed(mb);
    ua = ma;
    ub = mb;
    case (mop)
      3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd3: if (mb != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd4: if (mb != 0) begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                        input bit collide);
    int n;
    logic [31:0] ph, pl;
    n = (mop <= 3'd2) ? 5 : 10;
    start = 1'b1; op = mop; a = ma; b = mb; flush = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    ph = m_hi; pl = m_lo;
    model(mop, ma, mb);
    for (int j = 0; j < n; j++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("hi_hold", hi, ph);
      chk("lo_hold", lo, pl);
      if (collide) begin
        case (j)
          1: begin start = 1'b1; op = 3'd1; a = $urandom; b = $urandom; end
          2: begin start = 1'b0; op = 3'd6; a = $urandom; end
          3: begin op = 3'd0; flush = 1'b1; end
          4: flush = 1'b0;
          default: ;
        endcase
      end
      @(posedge clk); #1;
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi_result", hi, m_hi);
    chk("lo_result", lo, m_lo);
  endtask

  // One-cycle idle-state request: moves, no-op launches and flushed requests.
  task automatic idle_op(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         input logic mflush, input logic mstart);
    start = mstart; op = mop; a = ma; b = mb; flush = mflush;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; flush = 1'b0;
    if (!mflush && mop == 3'd5) m_hi = ma;
    if (!mflush && mop == 3'd6) m_lo = ma;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("hi_idle", hi, m_hi);
    chk("lo_idle", lo, m_lo);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_lo_const", lo, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_hi_const", hi, 32'd1);
    chk("multu_lo_const", lo, 32'hFFFFFFFE);
    run_op(3'd4, 32'd7, 32'd2, 1'b0);
    chk("divu_lo_const", lo, 32'd3);
    chk("divu_hi_const", hi, 32'd1);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);
    run_op(3'd1, 32'd1234, 32'd5678, 1'b0);
    run_op(3'd3, 32'd99, 32'd0, 1'b0);
    run_op(3'd4, 32'hDEADBEEF, 32'd0, 1'b0);

    idle_op(3'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
    chk("mthi_const", hi, 32'h12345678);
    idle_op(3'd6, 32'hCAFEF00D, 32'd0, 1'b1, 1'b0);
    idle_op(3'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    chk("flush_mult_busy", {31'd0, busy}, 32'd0);
    idle_op(3'd6, 32'h0BADF00D, 32'd0, 1'b0, 1'b1);
    idle_op(3'd0, 32'd5, 32'd6, 1'b0, 1'b1);
    idle_op(3'd7, 32'd5, 32'd6, 1'b0, 1'b1);

    run_op(3'd3, 32'hFFFFFF9C, 32'd7, 1'b1);
    run_op(3'd4, 32'd1000, 32'd33, 1'b1);

    // Asynchronous reset in the third busy cycle of a mult.
    start = 1'b1; op = 3'd1; a = 32'h00010001; b = 32'h00030003;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      chk("arst_busy_after", {31'd0, busy}, 32'd0);
      chk("arst_hi_after", hi, 32'd0);
      chk("arst_lo_after", lo, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] rop;
      logic [31:0] ra, rb;
      logic rfl;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      rfl = ($urandom_range(0, 4) == 0);
      if (rop >= 3'd1 && rop <= 3'd4 && !rfl)
        run_op(rop, ra, rb, ($urandom_range(0, 1) == 1) && rop >= 3'd3);
      else
        idle_op(rop, ra, rb, rfl, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU.
- Its operands come from the same EX operand path that the immediate extender and the forwarding muxes drive.
- Owns the HI/LO registers and serves mult/multu/div/divu/mthi/mtlo.
- Reports busy to hazard control, which stalls any MDU-class instruction in D while an operation is running.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch strobe for mult/multu/div/divu; sampled at the rising edge
- mdu_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
- flush  input  1  exception/eret in progress; suppresses the EX-stage MDU instruction this cycle
- a  input  32  operand A: rs value, or the source for mthi/mtlo
- b  input  32  operand B: rt value
- busy  output  1  high while an operation is in flight
- hi  output  32  HI register, read directly by mfhi
- lo  output  32  LO register, read directly by mflo

Behaviour:
- Reset (reset==0, asynchronous):
  - hi=0, lo=0, busy=0.
  - Cycle counter and captured operands/op cleared.
  - Reset asserted mid-operation aborts it; no HI/LO write occurs.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE -> RUN:
  - Condition: at edge k, start=1, flush=0, mdu_op in {1..4}.
  - a, b and op are captured at that edge.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy is 1 after edge k.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter goes 1->0, HI/LO are written and busy drops.
  - busy is high for exactly N cycles. Result is visible on hi/lo after edge k+N.
- Results:
  - mult: {hi,lo} = signed a × signed b, 64-bit.
  - multu: {hi,lo} = unsigned a × unsigned b, 64-bit.
  - div: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (div/divu with b==0): RUN still lasts DIV_CYCLES; hi and lo are left unchanged.
- mthi/mtlo:
  - Accepted only in IDLE with flush=0. At the edge, hi<=a or lo<=a respectively; busy stays 0.
  - The start value is irrelevant for ops 5/6.
  - Ignored in RUN; hazard control guarantees this does not happen, and the block does not corrupt state if it does.
- start in RUN: ignored. The in-flight operation is not restarted and its operands are not overwritten.
- start=1 with mdu_op in {0,5,6,7}: no launch. Ops 5/6 still follow the mthi/mtlo rule.
- flush:
  - Blocks a launch and blocks mthi/mtlo in the same cycle.
  - Does not cancel an operation already in RUN; it completes and writes HI/LO.
- Outputs:
  - hi/lo are registered and change only on the edges defined above.
  - busy is registered, with no combinational path from inputs.
- The multiply/divide may be a combinational operator on the captured operands, evaluated at the final edge, or an iterative datapath. Either way the cycle-visible behaviour above is mandatory.

Test Plan:
- Reset then mult:
  - Stimulus: release reset; start=1, mdu_op=1, a=0xFFFFFFFE (-2), b=3 for one cycle.
  - Required: busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0.
- multu and divu:
  - Stimulus: multu a=0xFFFFFFFF, b=2; then divu a=7, b=2.
  - Required: multu gives hi=1, lo=0xFFFFFFFE. divu gives busy for 10 cycles, then lo=3, hi=1.
- Signed div corner cases:
  - div a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - div with b=0: busy for 10 cycles, hi/lo unchanged from the prior values.
- mthi/mtlo and flush:
  - mthi a=0x12345678: hi updated next edge, busy never asserted.
  - mtlo with flush=1: lo unchanged.
  - start mult with flush=1: busy stays 0.
- Collisions during RUN:
  - Stimulus: during a running div, assert start/mult with new operands, then mtlo, then flush.
  - Required: the original div completes on schedule with its original result; lo is not overwritten by the mtlo.
- Asynchronous reset mid-op:
  - Stimulus: drive reset low at cycle 3 of a mult, between clock edges.
  - Required: busy, hi and lo go to 0 immediately; no late write after reset is released.
